// File: rtl/mmm_pkg.sv
// Shared fetch/execute definitions used across the front end.
//   XLEN         - architectural PC width
//   OFFSET       - low PC bits below instruction granularity (ignored for indexing)
//   resolution_t - branch resolution from execute: valid, taken, pc
package mmm_pkg;
  localparam int XLEN   = 32;
  localparam int OFFSET = 2;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pc;
  } resolution_t;
endpackage

// File: rtl/gshare_ghr.sv
// Speculative global history register for the gshare predictor.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   flush_i          clear history (highest priority)
//   recover_i        load recover_hist_i (misprediction repair)
//   recover_hist_i   complete repaired history value
//   shift_i          shift shift_bit_i in (speculative prediction)
//   shift_bit_i      predicted direction to shift in
//   hist_o           current history
module gshare_ghr #(
  parameter int HLEN = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            shift_i,
  input  logic            shift_bit_i,
  input  logic            recover_i,
  input  logic [HLEN-1:0] recover_hist_i,
  output logic [HLEN-1:0] hist_o
);
  logic [HLEN-1:0] hist_q, hist_d;

  // Recovery beats a same-cycle shift: that prediction is on the wrong path.
  always_comb begin
    hist_d = hist_q;
    if (flush_i)        hist_d = '0;
    else if (recover_i) hist_d = recover_hist_i;
    else if (shift_i)   hist_d = {hist_q[HLEN-2:0], shift_bit_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hist_q <= '0;
    else          hist_q <= hist_d;
  end

  assign hist_o = hist_q;
endmodule

// File: rtl/gshare_spec.sv
// Gshare direction predictor for fetch: PHT of saturating counters indexed
// by PC XOR speculative global history.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   flush_i          synchronous clear of GHR and PHT
//   pred_valid_i     fetch consumes the prediction this cycle (shifts GHR)
//   pc_i             fetch PC
//   taken_o          predicted direction (combinational)
//   hist_o           GHR used for this prediction, travels with the branch
//   res_i            resolution from execute (valid, taken, pc)
//   res_hist_i       hist_o snapshot carried by the resolving branch
//   res_mispred_i    resolved direction differs from the prediction
module gshare_spec
  import mmm_pkg::*;
#(
  parameter int HLEN     = 8,
  parameter int IDX_BITS = 10,
  parameter int CNT_BITS = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            pred_valid_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            taken_o,
  output logic [HLEN-1:0] hist_o,
  input  resolution_t     res_i,
  input  logic [HLEN-1:0] res_hist_i,
  input  logic            res_mispred_i
);
  localparam int                  ENTRIES  = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] INIT_CNT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  if (HLEN > IDX_BITS) begin : g_chk_hlen_max
    $error("gshare_spec: HLEN must not exceed IDX_BITS");
  end
  if (HLEN < 2) begin : g_chk_hlen_min
    $error("gshare_spec: HLEN must be at least 2");
  end
  if (CNT_BITS < 2) begin : g_chk_cnt
    $error("gshare_spec: CNT_BITS must be at least 2");
  end

  logic [HLEN-1:0]     ghr;
  logic [IDX_BITS-1:0] idx_r, idx_w;
  logic [CNT_BITS-1:0] pht_q [ENTRIES];
  logic [CNT_BITS-1:0] pht_d [ENTRIES];
  logic [CNT_BITS-1:0] cnt_w;

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i, res_i.pc};

  assign idx_r   = pc_i[IDX_BITS+OFFSET-1:OFFSET] ^ IDX_BITS'(ghr);
  assign idx_w   = res_i.pc[IDX_BITS+OFFSET-1:OFFSET] ^ IDX_BITS'(res_hist_i);
  // Reads registered state only: a same-cycle write is not bypassed.
  assign taken_o = pht_q[idx_r][CNT_BITS-1];
  assign hist_o  = ghr;
  assign cnt_w   = pht_q[idx_w];

  always_comb begin
    pht_d = pht_q;
    if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) pht_d[i] = INIT_CNT;
    end else if (res_i.valid) begin
      if (res_i.taken) begin
        if (cnt_w != CNT_MAX) pht_d[idx_w] = cnt_w + CNT_BITS'(1);
      end else begin
        if (cnt_w != '0) pht_d[idx_w] = cnt_w - CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= INIT_CNT;
    end else begin
      pht_q <= pht_d;
    end
  end

  // Repaired history = snapshot shifted with the actual outcome.
  gshare_ghr #(.HLEN(HLEN)) u_ghr (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .flush_i        (flush_i),
    .shift_i        (pred_valid_i),
    .shift_bit_i    (taken_o),
    .recover_i      (res_i.valid & res_mispred_i),
    .recover_hist_i ({res_hist_i[HLEN-2:0], res_i.taken}),
    .hist_o         (ghr)
  );
endmodule

// File: tb/tb_gshare_spec.sv
// Randomized + directed bench for gshare_spec (HLEN=4, IDX_BITS=4, CNT_BITS=2)
// against a behavioural counter/history model.
module tb_gshare_spec;
  import mmm_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n, flush, pv;
  logic [XLEN-1:0] pc;
  logic            taken;
  logic [3:0]      hist;
  resolution_t     res;
  logic [3:0]      rh;
  logic            rm;

  int total = 0;
  int bad   = 0;
  int mcnt [16];
  int mghr;

  always #5 clk = ~clk;

  gshare_spec #(.HLEN(4), .IDX_BITS(4), .CNT_BITS(2)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .pred_valid_i (pv),
    .pc_i         (pc),
    .taken_o      (taken),
    .hist_o       (hist),
    .res_i        (res),
    .res_hist_i   (rh),
    .res_mispred_i(rm)
  );

  function automatic logic [XLEN-1:0] mkpc(int idx);
    logic [XLEN-1:0] r;
    logic [3:0]      i4;
    r  = $urandom;
    i4 = idx[3:0];
    r[OFFSET+3:OFFSET] = i4;
    return r;
  endfunction

  function automatic int pidx(logic [XLEN-1:0] p);
    return int'(p[OFFSET+3:OFFSET]);
  endfunction

  function automatic logic m_taken();
    return (mcnt[(pidx(pc) ^ mghr) & 15] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mcnt[i] = 1;
    mghr = 0;
  endtask

  task automatic idle();
    pv = 0; flush = 0; res = '0; rh = '0; rm = 0; pc = mkpc(0);
  endtask

  task automatic res_drive(logic t, int pci, int h, logic m);
    res.valid = 1'b1; res.taken = t; res.pc = mkpc(pci); rh = h[3:0]; rm = m;
  endtask

  // Apply the predictor rules to the model, then advance one clock.
  task automatic tick();
    int  w;
    logic pt;
    pt = m_taken();
    if (flush) begin
      m_reset();
    end else begin
      if (res.valid) begin
        w = (pidx(res.pc) ^ int'(rh)) & 15;
        if (res.taken) mcnt[w] = (mcnt[w] == 3) ? 3 : mcnt[w] + 1;
        else           mcnt[w] = (mcnt[w] == 0) ? 0 : mcnt[w] - 1;
      end
      if (res.valid && rm) mghr = ((int'(rh) << 1) | int'(res.taken)) & 15;
      else if (pv)         mghr = ((mghr << 1) | int'(pt)) & 15;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      pc = mkpc(i);
      #1;
      total++;
      if (taken !== 1'b0 || hist !== 4'h0) begin
        bad++;
        $display("FAIL reset idx=%0d taken=%b hist=%h want taken=0 hist=0", i, taken, hist);
      end
    end
  endtask

  task automatic test_training();
    logic exp_t [7];
    exp_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    idle();
    for (int k = 0; k < 7; k++) begin
      res_drive(k < 3, 0, 0, 0);
      tick();
      idle();
      #1;
      total++;
      if (taken !== exp_t[k] || taken !== m_taken() || hist !== 4'h0) begin
        bad++;
        $display("FAIL training step=%0d taken=%b hist=%h want taken=%b hist=0",
                 k, taken, hist, exp_t[k]);
      end
    end
  endtask

  task automatic test_spec_shift();
    idle();
    for (int k = 0; k < 3; k++) begin res_drive(1, 0, 0, 0); tick(); end
    idle();
    pv = 1; pc = mkpc(0);
    #1;
    total++;
    if (taken !== 1'b1 || hist !== 4'b0000) begin
      bad++; $display("FAIL shift_c0 taken=%b hist=%b want 1/0000", taken, hist);
    end
    tick();
    pc = mkpc(0);
    #1;
    total++;
    if (taken !== 1'b0 || hist !== 4'b0001) begin
      bad++; $display("FAIL shift_c1 taken=%b hist=%b want 0/0001", taken, hist);
    end
    tick();
    pv = 0;
    #1;
    total++;
    if (hist !== 4'b0010) begin
      bad++; $display("FAIL shift_c2 hist=%b want 0010", hist);
    end
  endtask

  task automatic test_recover_priority();
    idle();
    res_drive(1, 8, 4'b0101, 1);
    tick();
    idle();
    #1;
    total++;
    if (hist !== 4'b1011) begin
      bad++; $display("FAIL recover_setup hist=%b want 1011", hist);
    end
    pv = 1; pc = mkpc(0);
    res_drive(0, 3, 4'b0101, 1);
    tick();
    idle();
    #1;
    total++;
    if (hist !== 4'b1010) begin
      bad++; $display("FAIL recover_prio hist=%b want 1010", hist);
    end
    // idx 6 went 1 -> 0; one taken step leaves it at 1, so still not-taken.
    res_drive(1, 6, 0, 0);
    tick();
    idle();
    pc = mkpc(12);
    #1;
    total++;
    if (taken !== 1'b0 || taken !== m_taken()) begin
      bad++; $display("FAIL recover_dec taken=%b want 0", taken);
    end
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 3; k++) begin res_drive(1, 0, 0, 0); tick(); end
    res_drive(0, 1, 4'b0011, 1);
    tick();
    idle();
    #1;
    total++;
    if (hist !== 4'b0110) begin
      bad++; $display("FAIL flush_setup hist=%b want 0110", hist);
    end
    flush = 1;
    res_drive(0, 0, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 16; i++) begin
      pc = mkpc(i);
      #1;
      total++;
      if (taken !== 1'b0 || hist !== 4'h0) begin
        bad++; $display("FAIL flush_clear idx=%0d taken=%b hist=%h want 0/0", i, taken, hist);
      end
    end
    res_drive(1, 0, 0, 0);
    tick();
    idle();
    #1;
    total++;
    if (taken !== 1'b1) begin
      bad++; $display("FAIL flush_drop taken=%b want 1", taken);
    end
  endtask

  task automatic test_no_bypass();
    idle();
    flush = 1;
    tick();
    idle();
    res_drive(1, 0, 0, 0);
    #1;
    total++;
    if (taken !== 1'b0) begin
      bad++; $display("FAIL bypass_same taken=%b want 0", taken);
    end
    tick();
    idle();
    #1;
    total++;
    if (taken !== 1'b1) begin
      bad++; $display("FAIL bypass_next taken=%b want 1", taken);
    end
  endtask

  task automatic test_async_reset();
    idle();
    pv = 1; pc = mkpc(5);
    tick(); tick();
    res_drive(1, 0, 0, 0);
    #2;
    rst_n = 0;
    m_reset();
    #1;
    idle();
    #1;
    total++;
    if (taken !== 1'b0 || hist !== 4'h0) begin
      bad++; $display("FAIL async_reset taken=%b hist=%h want 0/0", taken, hist);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    #1;
    total++;
    if (taken !== 1'b0 || hist !== 4'h0) begin
      bad++; $display("FAIL async_release taken=%b hist=%h want 0/0", taken, hist);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      pv        = 1'($urandom_range(0, 1));
      pc        = mkpc($urandom_range(0, 15));
      flush     = ($urandom_range(0, 31) == 0);
      res.valid = 1'($urandom_range(0, 1));
      res.taken = 1'($urandom_range(0, 1));
      res.pc    = mkpc($urandom_range(0, 15));
      rh        = 4'($urandom_range(0, 15));
      rm        = ($urandom_range(0, 3) == 0);
      #1;
      total++;
      if (taken !== m_taken() || hist !== mghr[3:0]) begin
        bad++;
        $display("FAIL random n=%0d taken=%b hist=%h want taken=%b hist=%h",
                 n, taken, hist, m_taken(), mghr[3:0]);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_reset();
    test_reset();
    test_training();
    test_spec_shift();
    test_recover_priority();
    test_flush();
    test_no_bypass();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
